// File: rtl/dist_lut_fifo_if.sv
// Handshake bundle for dist_lut_fifo: write side, read side and status.
// The o_count width follows DIST_LUT_FIFO_OUT_REG_EN (one extra bit when the output register is built).
interface dist_lut_fifo_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
`ifdef DIST_LUT_FIFO_OUT_REG_EN
    localparam int CNT_W = ADDR_WIDTH + 2;
`else
    localparam int CNT_W = ADDR_WIDTH + 1;
`endif

    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  o_rd_valid;
    logic                  i_rd_ready;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic [CNT_W-1:0]      o_count;
    logic                  o_full;
    logic                  o_empty;

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_count, o_full, o_empty
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data, o_count, o_full, o_empty
    );
endinterface

// File: rtl/dist_lut_fifo.sv
// First-word-fall-through FIFO on a LUT memory (sync write, async read).
// Optional DIST_LUT_FIFO_OUT_REG_EN adds a registered output stage (capacity DEPTH+1).
module dist_lut_fifo #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    dist_lut_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef DIST_LUT_FIFO_OUT_REG_EN
    localparam int CNT_W = ADDR_WIDTH + 2;
`else
    localparam int CNT_W = ADDR_WIDTH + 1;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   st_count;
    logic                  st_empty;
    logic                  st_full;
    logic                  push;
    logic                  st_pop;
    logic [DATA_WIDTH-1:0] head_p0;

    assign st_empty = (wr_ptr == rd_ptr);
    assign st_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign st_count = wr_ptr - rd_ptr;
    assign push     = bus.i_wr_valid && !st_full;
    assign head_p0  = mem[rd_ptr[ADDR_WIDTH-1:0]];

    assign bus.o_wr_ready = !st_full;
    assign bus.o_full     = st_full;

    // Stage p0: storage write and pointer update
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (st_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef DIST_LUT_FIFO_OUT_REG_EN
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // The head moves into the output register when that register is free or being drained.
    assign st_pop = !st_empty && (!vld_p1 || bus.i_rd_ready);

    // Stage p1: registered output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
        end else if (st_pop) begin
            vld_p1 <= 1'b1;
        end else if (bus.i_rd_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (st_pop) begin
            data_p1 <= head_p0;
        end
    end

    assign bus.o_rd_valid = vld_p1;
    assign bus.o_rd_data  = data_p1;
    assign bus.o_count    = {1'b0, st_count} + CNT_W'(vld_p1);
    assign bus.o_empty    = st_empty && !vld_p1;
`else
    assign st_pop         = !st_empty && bus.i_rd_ready;
    assign bus.o_rd_valid = !st_empty;
    assign bus.o_rd_data  = head_p0;
    assign bus.o_count    = CNT_W'(st_count);
    assign bus.o_empty    = st_empty;
`endif
endmodule

// File: tb/tb_dist_lut_fifo.sv
// Directed plus randomized bench for dist_lut_fifo (default build) against a queue model.
module tb_dist_lut_fifo;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   errors;
    logic [DATA_WIDTH-1:0] model_q [$];

    dist_lut_fifo_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    dist_lut_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"},    64'(bus.o_count), 64'(n));
        check({tag, ".empty"},    64'(bus.o_empty), 64'(n == 0));
        check({tag, ".full"},     64'(bus.o_full), 64'(n == DEPTH));
        check({tag, ".rd_valid"}, 64'(bus.o_rd_valid), 64'(n != 0));
        check({tag, ".wr_ready"}, 64'(bus.o_wr_ready), 64'(n != DEPTH));
        if (n != 0) begin
            check({tag, ".rd_data"}, 64'(bus.o_rd_data), 64'(model_q[0]));
        end
    endtask

    // One clock cycle with the given request; the model applies push/pop by queue rules.
    task automatic step(input logic wv, input logic [DATA_WIDTH-1:0] wd, input logic rr,
                        input string tag);
        bit do_push;
        bit do_pop;
        bus.i_wr_valid = wv;
        bus.i_wr_data  = wd;
        bus.i_rd_ready = rr;
        do_push = wv && (model_q.size() < DEPTH);
        do_pop  = rr && (model_q.size() > 0);
        @(posedge i_clk);
        if (do_pop) begin
            void'(model_q.pop_front());
        end
        if (do_push) begin
            model_q.push_back(wd);
        end
        #1;
        check_all(tag);
        bus.i_wr_valid = 1'b0;
        bus.i_rd_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;
        i_rst_n = 1'b0;

        #2;
        check_all("reset");
        repeat (3) @(posedge i_clk);
        #1;
        check_all("reset_held");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check_all("idle");

        step(1'b1, 32'hA5A5_0001, 1'b0, "single_push");
        check("single_push.data", 64'(bus.o_rd_data), 64'h0000_0000_A5A5_0001);
        step(1'b0, '0, 1'b1, "single_pop");

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'(i), 1'b0, "fill");
        end
        check("fill.count32", 64'(bus.o_count), 64'd32);
        step(1'b1, 32'hDEAD, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.order", 64'(bus.o_rd_data), 64'(i));
            step(1'b0, '0, 1'b1, "drain");
        end
        step(1'b0, '0, 1'b1, "underflow");

        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 1'b0, "pre_stream");
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, $urandom, 1'b1, "stream");
        end
        check("stream.count3", 64'(bus.o_count), 64'd3);

        while (model_q.size() < DEPTH) begin
            step(1'b1, $urandom, 1'b0, "refill");
        end
        step(1'b1, 32'hBEEF, 1'b1, "full_push_pop");
        check("full_push_pop.count31", 64'(bus.o_count), 64'd31);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "random");
        end

        while (model_q.size() > 0) begin
            step(1'b0, '0, 1'b1, "flush");
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, 1'b0, "pre_reset");
        end
        #3;
        i_rst_n = 1'b0;
        model_q.delete();
        #1;
        check_all("mid_reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(1'b1, 32'h1234, 1'b0, "post_reset");
        check("post_reset.data", 64'(bus.o_rd_data), 64'h1234);
        check("post_reset.count1", 64'(bus.o_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
